// File: rtl/oser_pattern_gen.sv
// ============================================================================
// Module  : oser_pattern_gen
// Brief   : OSER4/OSER8 clock and test-pattern generator (ALT/COUNTER/PRBS7/WALK).
//           Define OSER_PATGEN_ERRINJ_EN to build single-bit error injection.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module oser_pattern_gen #(
  parameter int CH        = 2,
  parameter int RATIO     = 8,
  parameter int FCLK_HALF = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic                  inject_i,
  output logic                  fclk_o,
  output logic                  pclk_o,
  output logic [CH*RATIO-1:0]   d_o,
  output logic                  word_stb_o,
  output logic                  inj_ack_o
);

  // Phase is kept as (half-period index, cycle within half-period) so that
  // ph = r_hi*FCLK_HALF + r_hc, avoiding any divide by FCLK_HALF.
  localparam int c_HC_W = (FCLK_HALF > 1) ? $clog2(FCLK_HALF) : 1;
  localparam int c_HI_W = $clog2(RATIO);
  localparam logic [c_HC_W-1:0] c_HC_LAST = c_HC_W'(FCLK_HALF - 1);
  localparam logic [c_HI_W-1:0] c_HI_LAST = c_HI_W'(RATIO - 1);
  localparam logic [c_HI_W-1:0] c_HI_LOAD = c_HI_W'(RATIO / 2 - 1);

  localparam logic [1:0] c_MODE_ALT  = 2'd0;
  localparam logic [1:0] c_MODE_CNT  = 2'd1;
  localparam logic [1:0] c_MODE_PRBS = 2'd2;
  localparam logic [1:0] c_MODE_WALK = 2'd3;

  function automatic logic [CH*7-1:0] f_seeds();
    logic [CH*7-1:0] s;
    s = '0;
    for (int c = 0; c < CH; c++) s[c*7 +: 7] = 7'h7F ^ 7'(c);
    return s;
  endfunction

  localparam logic [CH*7-1:0] c_SEEDS = f_seeds();

  logic [c_HC_W-1:0]   r_hc;
  logic [c_HI_W-1:0]   r_hi;
  logic [RATIO-1:0]    r_k;
  logic [1:0]          r_mode;
  logic [CH*7-1:0]     r_lfsr;

  logic                w_hc_wrap;
  logic [c_HC_W-1:0]   w_hc_nxt;
  logic [c_HI_W-1:0]   w_hi_nxt;
  logic                w_load;
  logic                w_restart;
  logic [RATIO-1:0]    w_k;
  logic [CH*RATIO-1:0] w_words;
  logic [CH*7-1:0]     w_lfsr_nxt;
  logic                w_flip;

  assign w_hc_wrap = (r_hc == c_HC_LAST);
  assign w_hc_nxt  = w_hc_wrap ? '0 : r_hc + 1'b1;
  assign w_hi_nxt  = !w_hc_wrap ? r_hi : ((r_hi == c_HI_LAST) ? '0 : r_hi + 1'b1);
  // pclk rises when the next phase equals P/2.
  assign w_load    = en_i && w_hc_wrap && (r_hi == c_HI_LOAD);
  assign w_restart = (mode_i != r_mode);
  assign w_k       = w_restart ? '0 : r_k;

  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [RATIO-1:0] w_cnt;
      logic [RATIO-1:0] w_walk;
      logic [RATIO-1:0] w_prbs;
      logic [RATIO-1:0] w_word;
      logic [6:0]       w_s;

      assign w_cnt  = w_k + RATIO'(c);
      assign w_walk = {{(RATIO-1){1'b0}}, 1'b1} << w_cnt[c_HI_W-1:0];

      always_comb begin
        w_s    = w_restart ? c_SEEDS[c*7 +: 7] : r_lfsr[c*7 +: 7];
        w_prbs = '0;
        for (int b = 0; b < RATIO; b++) begin
          w_prbs[b] = w_s[6] ^ w_s[5];
          w_s       = {w_s[5:0], w_prbs[b]};
        end
      end

      always_comb begin
        w_word = '0;
        case (mode_i)
          c_MODE_ALT:  w_word = {(RATIO/2){2'b01}};
          c_MODE_CNT:  w_word = w_cnt;
          c_MODE_PRBS: w_word = w_prbs;
          c_MODE_WALK: w_word = w_walk;
          default:     w_word = '0;
        endcase
      end

      assign w_words[c*RATIO +: RATIO] = w_word;
      assign w_lfsr_nxt[c*7 +: 7]      = w_s;
    end
  endgenerate

`ifdef OSER_PATGEN_ERRINJ_EN
  logic r_pend;

  assign w_flip = r_pend;

  // A request seen in the load cycle itself is held for the following load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend    <= 1'b0;
      inj_ack_o <= 1'b0;
    end else if (en_i) begin
      inj_ack_o <= w_load && r_pend;
      if (w_load)        r_pend <= inject_i;
      else if (inject_i) r_pend <= 1'b1;
    end else begin
      inj_ack_o <= 1'b0;
    end
  end
`else
  logic w_unused_inject;

  assign w_unused_inject = inject_i;
  assign w_flip          = 1'b0;
  assign inj_ack_o       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hc       <= '0;
      r_hi       <= '0;
      fclk_o     <= 1'b0;
      pclk_o     <= 1'b0;
      d_o        <= '0;
      word_stb_o <= 1'b0;
      r_k        <= '0;
      r_mode     <= c_MODE_ALT;
      r_lfsr     <= c_SEEDS;
    end else if (en_i) begin
      r_hc       <= w_hc_nxt;
      r_hi       <= w_hi_nxt;
      fclk_o     <= ~w_hi_nxt[0];
      pclk_o     <= w_hi_nxt[c_HI_W-1];
      word_stb_o <= w_load;
      if (w_load) begin
        d_o    <= w_words ^ {{(CH*RATIO-1){1'b0}}, w_flip};
        r_mode <= mode_i;
        r_k    <= w_k + 1'b1;
        if (mode_i == c_MODE_PRBS) r_lfsr <= w_lfsr_nxt;
      end
    end else begin
      word_stb_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oser_pattern_gen.sv
// ============================================================================
// Module  : tb_oser_pattern_gen
// Brief   : Self-checking bench for oser_pattern_gen (directed table + random).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oser_pattern_gen;
  localparam int CH = 2, RATIO = 8, FH = 2, P = RATIO * FH, W = CH * RATIO;

  logic         clk = 1'b0;
  logic         rst = 1'b1, en = 1'b0, inject = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         fclk_o, pclk_o, word_stb_o, inj_ack_o;
  logic [W-1:0] d_o;

  int n_tests = 0, n_fail = 0;

  oser_pattern_gen #(.CH(CH), .RATIO(RATIO), .FCLK_HALF(FH)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .inject_i(inject),
    .fclk_o(fclk_o), .pclk_o(pclk_o), .d_o(d_o),
    .word_stb_o(word_stb_o), .inj_ack_o(inj_ack_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase arithmetic plus precomputed PRBS bit streams.
  int           m_ph, m_k, m_prev;
  bit           m_fclk, m_pclk, m_stb, m_ack, m_pend;
  logic [W-1:0] m_d;
  int           m_pos[CH];
  bit           x[CH][134];

  function automatic void model_init();
    logic [6:0] seed;
    for (int c = 0; c < CH; c++) begin
      seed = 7'h7F ^ 7'(c);
      for (int n = 0; n < 7; n++) x[c][n] = seed[6-n];
      for (int n = 7; n < 134; n++) x[c][n] = x[c][n-7] ^ x[c][n-6];
      m_pos[c] = 0;
    end
    m_ph = 0; m_k = 0; m_prev = 0; m_fclk = 0; m_pclk = 0;
    m_stb = 0; m_ack = 0; m_pend = 0; m_d = '0;
  endfunction

  function automatic void model_step(bit r, bit e, int md, bit inj);
    bit               np, ld;
    logic [RATIO-1:0] wd;
    if (r) begin
      m_ph = 0; m_k = 0; m_prev = 0; m_fclk = 0; m_pclk = 0;
      m_stb = 0; m_ack = 0; m_pend = 0; m_d = '0;
      for (int c = 0; c < CH; c++) m_pos[c] = 0;
    end else if (e) begin
      m_ph   = (m_ph + 1) % P;
      m_fclk = ((m_ph / FH) % 2) == 0;
      np     = m_ph >= P / 2;
      ld     = np && !m_pclk;
      m_pclk = np;
      m_stb  = ld;
      m_ack  = 0;
      if (ld) begin
        if (md != m_prev) begin
          m_k = 0;
          for (int c = 0; c < CH; c++) m_pos[c] = 0;
        end
        m_prev = md;
        for (int c = 0; c < CH; c++) begin
          wd = '0;
          case (md)
            0: for (int b = 0; b < RATIO; b++) wd[b] = (b % 2) == 0;
            1: wd = RATIO'((m_k + c) % (1 << RATIO));
            2: for (int b = 0; b < RATIO; b++) wd[b] = x[c][7 + ((m_pos[c] + b) % 127)];
            default: wd = RATIO'(1 << ((m_k + c) % RATIO));
          endcase
          m_d[c*RATIO +: RATIO] = wd;
        end
        if (md == 2) for (int c = 0; c < CH; c++) m_pos[c] = (m_pos[c] + RATIO) % 127;
        m_k = (m_k + 1) % (1 << RATIO);
`ifdef OSER_PATGEN_ERRINJ_EN
        if (m_pend) begin
          m_d[0] = ~m_d[0];
          m_ack  = 1;
        end
        m_pend = inj;
`endif
      end else begin
`ifdef OSER_PATGEN_ERRINJ_EN
        if (inj) m_pend = 1;
`endif
      end
    end else begin
      m_stb = 0;
      m_ack = 0;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(rst, en, int'(mode), inject);
    check("model", {fclk_o, pclk_o, word_stb_o, inj_ack_o, d_o},
                   {m_fclk, m_pclk, m_stb, m_ack, m_d});
  endtask

  task automatic wait_stb(input int budget, output int cycles);
    bit ok;
    ok = 0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      tick();
      cycles++;
      if (word_stb_o) ok = 1;
    end
    check("stb_seen", 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          cyc, last_rise, prev_rise;
    logic [7:0]  first_w, w;
    logic [W+3:0] snap;
    bit          zero_seen;

    model_init();
    tbl[0] = '{2'd1, 8'h00, 8'h01};
    tbl[1] = '{2'd1, 8'h01, 8'h02};
    tbl[2] = '{2'd1, 8'h02, 8'h03};
    tbl[3] = '{2'd3, 8'h01, 8'h02};
    tbl[4] = '{2'd3, 8'h02, 8'h04};
    tbl[5] = '{2'd1, 8'h00, 8'h01};
    tbl[6] = '{2'd0, 8'h55, 8'h55};
    tbl[7] = '{2'd2, 8'h40, 8'h20};

    // Reset state
    rst = 1; en = 1; mode = 0;
    tick(); tick();
    check("reset_outputs", {fclk_o, pclk_o, word_stb_o, inj_ack_o, d_o}, '0);
    rst = 0;

    // First load at enabled cycle 8, fclk period 4
    last_rise = 0; prev_rise = 0; cyc = 0;
    while (!word_stb_o && cyc < 40) begin
      logic f_old;
      f_old = fclk_o;
      tick();
      cyc++;
      if (fclk_o && !f_old) begin
        prev_rise = last_rise;
        last_rise = cyc;
      end
    end
    check("first_load_cycle", 64'(cyc), 64'd8);
    check("fclk_period", 64'(last_rise - prev_rise), 64'd4);
    check("alt_word", 64'(d_o), 64'h5555);

    // Directed table of mode sequences
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode;
      wait_stb(40, cyc);
      check($sformatf("tbl%0d_ch0", i), 64'(d_o[7:0]), 64'(tbl[i].e0));
      check($sformatf("tbl%0d_ch1", i), 64'(d_o[15:8]), 64'(tbl[i].e1));
    end

    // PRBS7 period of 127 loads, never an all-zero word
    first_w = d_o[7:0];
    zero_seen = 0;
    w = '0;
    for (int i = 1; i <= 127; i++) begin
      wait_stb(40, cyc);
      w = d_o[7:0];
      if (w == 8'h00) zero_seen = 1;
    end
    check("prbs_period", 64'(w), 64'(first_w));
    check("prbs_nonzero", 64'(zero_seen), 64'd0);

    // Counter across the FF->00 wrap
    mode = 1;
    for (int i = 0; i < 257; i++) begin
      wait_stb(40, cyc);
      check("cnt_ch0", 64'(d_o[7:0]), 64'(i % 256));
      check("cnt_ch1", 64'(d_o[15:8]), 64'((i + 1) % 256));
    end

    // Freeze with en low mid-period, then reset mid-word
    mode = 0;
    tick(); tick(); tick();
    snap = {fclk_o, pclk_o, 1'b0, 1'b0, d_o};
    en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("freeze", {fclk_o, pclk_o, word_stb_o, inj_ack_o, d_o}, 64'(snap));
    end
    en = 1;
    tick(); tick();
    rst = 1;
    tick();
    check("midword_reset", {fclk_o, pclk_o, word_stb_o, inj_ack_o, d_o}, '0);
    rst = 0;
    wait_stb(40, cyc);
    check("reload_cycle", 64'(cyc), 64'd8);

    // Error injection
    inject = 1;
    tick();
    inject = 0;
    wait_stb(40, cyc);
`ifdef OSER_PATGEN_ERRINJ_EN
    check("inj_word", 64'(d_o[7:0]), 64'h54);
    check("inj_ack", 64'(inj_ack_o), 64'd1);
    wait_stb(40, cyc);
    check("post_inj_word", 64'(d_o[7:0]), 64'h55);
    check("post_inj_ack", 64'(inj_ack_o), 64'd0);
`else
    check("noinj_word", 64'(d_o[7:0]), 64'h55);
    check("noinj_ack", 64'(inj_ack_o), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom % 400) == 0;
      en     = ($urandom % 8) != 0;
      inject = ($urandom % 25) == 0;
      if (($urandom % 40) == 0) mode = 2'($urandom % 4);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
